sipo_div: RTL and testbench

//   Serial-in parallel-out receiver; the far end of the PISO_div serial link.

---
 rtl/sipo_div_pkg.sv | 25 ++
 rtl/sipo_bit_tick.sv | 36 +++
 rtl/sipo_div.sv | 154 +++++++++++++++
 tb/tb_sipo_div.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_div_pkg.sv
// Shared types and width helpers for the sipo_div serial receiver.
package sipo_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIV   = 4;

  // Bit-period counter width; DIV is at least 2, so this is never 0.
  function automatic int cnt_w(input int div);
    return $clog2(div);
  endfunction

  // Data-bit counter must be able to hold WIDTH itself.
  function automatic int bitcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_bit_tick.sv
// Bit-period down-counter: tick whenever the count is zero, reload to half or full period,
// freeze while the receiver idles. Tick is combinational from the count register.
module sipo_bit_tick
  import sipo_div_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hold,
  input  logic i_load_half,
  input  logic i_load_full,
  output logic o_tick
);

  localparam int CW = cnt_w(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load_half) begin
      r_cnt <= HALF;
    end else if (i_load_full) begin
      r_cnt <= FULL;
    end else if (!i_hold && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/sipo_div.sv
// Serial receiver: 2-flop sync, start/mid-bit sampling, stop check, parallel word + valid pulse.
// Define SIPO_DIV_PARITY_EN to add an even-parity bit between data and stop; no backpressure.
module sipo_div
  import sipo_div_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV       = DEF_DIV,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int BW = bitcnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;

  logic             w_s_in;
  logic             w_tick;
  logic             w_hold;
  logic             w_load_half;
  logic             w_load_full;
  logic             w_par_ok;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_s_in = r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_nxt = {r_shreg[WIDTH-2:0], w_s_in};
    end else begin : g_lsb_first
      assign w_shift_nxt = {w_s_in, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  // First low sample arms a half-bit wait so later ticks land mid-bit.
  assign w_hold      = (r_state == IDLE);
  assign w_load_half = (r_state == IDLE) && !w_s_in;
  assign w_load_full = w_tick && (((r_state == START) && !w_s_in) ||
                                  (r_state == DATA) || (r_state == PARITY));

  sipo_bit_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .i_hold      (w_hold),
    .i_load_half (w_load_half),
    .i_load_full (w_load_full),
    .o_tick      (w_tick)
  );

`ifdef SIPO_DIV_PARITY_EN
  logic r_par;
  logic r_par_err;
  assign w_par_ok = !r_par_err;
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef SIPO_DIV_PARITY_EN
      r_par     <= 1'b0;
      r_par_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_s_in) r_state <= START;
        end
        START: begin
          if (w_tick) begin
            if (w_s_in) begin
              r_state <= IDLE;
            end else begin
              r_state  <= DATA;
              r_bitcnt <= '0;
`ifdef SIPO_DIV_PARITY_EN
              r_par     <= 1'b0;
              r_par_err <= 1'b0;
`endif
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shreg  <= w_shift_nxt;
            r_bitcnt <= r_bitcnt + BW'(1);
`ifdef SIPO_DIV_PARITY_EN
            r_par <= r_par ^ w_s_in;
            if (r_bitcnt == LAST_BIT) r_state <= PARITY;
`else
            if (r_bitcnt == LAST_BIT) r_state <= STOP;
`endif
          end
        end
        PARITY: begin
`ifdef SIPO_DIV_PARITY_EN
          if (w_tick) begin
            r_par_err <= r_par ^ w_s_in;
            r_state   <= STOP;
          end
`else
          r_state <= IDLE;
`endif
        end
        STOP: begin
          if (w_tick) begin
            if (w_s_in && w_par_ok) begin
              data_out <= r_shreg;
              valid    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_sipo_div.sv
// Randomized self-checking bench for sipo_div against a frame-level event model.
module tb_sipo_div;

  localparam int WIDTH     = 32;
  localparam int DIV       = 4;
  localparam bit MSB_FIRST = 1'b1;
`ifdef SIPO_DIV_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME = (WIDTH + 2 + PBITS) * DIV;
  // sync + half bit + data/parity/stop bits + output register
  localparam int LAT   = 2 + DIV / 2 + (WIDTH + PBITS + 1) * DIV + 1;

  typedef struct {
    bit               ferr;
    longint           cyc;
    logic [WIDTH-1:0] dat;
  } ev_t;

  logic             clk;
  logic             rst;
  logic             serial_in;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             frame_err;

  ev_t              obs_q[$];
  ev_t              exp_q[$];
  longint           cyc = 0;
  int               n_tests = 0;
  int               n_fail = 0;
  int               n_both = 0;
  logic [WIDTH-1:0] last_good = '0;

  sipo_div #(
    .WIDTH     (WIDTH),
    .DIV       (DIV),
    .MSB_FIRST (MSB_FIRST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    ev_t ev;
    if (rst) begin
      ev.cyc = cyc;
      ev.dat = data_out;
      if (valid) begin
        ev.ferr = 1'b0;
        obs_q.push_back(ev);
      end
      if (frame_err) begin
        ev.ferr = 1'b1;
        obs_q.push_back(ev);
      end
      if (valid && frame_err) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    serial_in = b;
    repeat (DIV) @(negedge clk);
  endtask

  // Called just after a negedge; records what the receiver should report for this frame.
  task automatic send_frame(input logic [WIDTH-1:0] w, input bit stop_ok, input bit par_ok);
    ev_t    e;
    longint t0;
    bit     good;
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < WIDTH; i++) drive_bit(MSB_FIRST ? w[WIDTH-1-i] : w[i]);
`ifdef SIPO_DIV_PARITY_EN
    drive_bit((^w) ^ !par_ok);
`endif
    drive_bit(stop_ok);
    serial_in = 1'b1;
    good   = stop_ok && par_ok;
    if (good) last_good = w;
    e.ferr = !good;
    e.cyc  = t0 + LAT;
    e.dat  = last_good;
    exp_q.push_back(e);
  endtask

  task automatic check_events(input string tag);
    ev_t e;
    ev_t o;
    chk($sformatf("%s_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk($sformatf("%s_kind", tag), 64'(o.ferr), 64'(e.ferr));
      chk($sformatf("%s_cycle", tag), 64'(o.cyc), 64'(e.cyc));
      chk($sformatf("%s_data", tag), 64'(o.dat), 64'(e.dat));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    longint t0;
    bit     rose;
    bit     fell;
    bit     prev_bad;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] part;

    rst       = 1'b0;
    serial_in = 1'b1;
    #5 rst = 1'b1;
    @(negedge clk);
    chk("reset_data", 64'(data_out), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ferr", 64'(frame_err), 64'd0);
    repeat (200) @(negedge clk);
    chk("idle_no_events", 64'(obs_q.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // single good frame with latency measured from the start edge
    t0 = cyc;
    send_frame(32'h7FFF_FFFE, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("good_latency", (obs_q.size() > 0) ? 64'(obs_q[0].cyc - t0) : 64'hFFFF, 64'(LAT));
    check_events("good");

    // one-cycle glitch
    serial_in = 1'b0;
    @(negedge clk);
    serial_in = 1'b1;
    rose = 1'b0;
    fell = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (busy) rose = 1'b1;
      if (rose && !busy) fell = 1'b1;
    end
    chk("glitch_busy_rose", 64'(rose), 64'd1);
    chk("glitch_busy_fell", 64'(fell), 64'd1);
    repeat (10) @(negedge clk);
    chk("glitch_no_events", 64'(obs_q.size()), 64'd0);

    // bad stop bit
    send_frame(32'hA5A5_A5A5, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check_events("badstop");
    chk("badstop_data_kept", 64'(data_out), 64'(last_good));

    // back-to-back frames
    send_frame(32'h0000_0001, 1'b1, 1'b1);
    send_frame(32'hFFFF_FFFF, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    chk("b2b_spacing", (obs_q.size() > 1) ? 64'(obs_q[1].cyc - obs_q[0].cyc) : 64'hFFFF,
        64'(FRAME));
    check_events("b2b");

    // reset after bit 10 of a frame
    part = 32'h1234_5678;
    drive_bit(1'b0);
    for (int i = 0; i < 11; i++) drive_bit(part[WIDTH-1-i]);
    rst = 1'b0;
    #1;
    chk("midrst_data", 64'(data_out), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_ferr", 64'(frame_err), 64'd0);
    #2 rst = 1'b1;
    serial_in = 1'b1;
    last_good = '0;
    repeat (2 * FRAME) @(negedge clk);
    chk("midrst_no_events", 64'(obs_q.size()), 64'd0);
    send_frame(32'hC3C3_5A5A, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check_events("after_rst");
`ifdef SIPO_DIV_PARITY_EN
    send_frame(32'h0F0F_1234, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check_events("bad_parity");
`endif

    // randomized frames, idle gaps and bad stop bits
    prev_bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (prev_bad || ($urandom_range(0, 2) == 0))
        repeat ($urandom_range(DIV + 2, 3 * DIV)) @(negedge clk);
      case ($urandom_range(0, 5))
        0:       w = '0;
        1:       w = '1;
        default: w = WIDTH'($urandom);
      endcase
      prev_bad = ($urandom_range(0, 4) == 0);
`ifdef SIPO_DIV_PARITY_EN
      send_frame(w, !prev_bad, ($urandom_range(0, 4) != 0));
      prev_bad = prev_bad || (exp_q[exp_q.size()-1].ferr == 1'b1);
`else
      send_frame(w, !prev_bad, 1'b1);
`endif
    end
    repeat (10) @(negedge clk);
    check_events("rand");
    chk("rand_final_data", 64'(data_out), 64'(last_good));
    chk("valid_ferr_exclusive", 64'(n_both), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
